dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  MEM_WORDS, 1024, data memory depth in 64-bit words
  MEM_LAT, 1, cycles from mem_en sampled to mem_rdata valid (1..4)
  STARVE_LIMIT, 2, consecutive contested data grants before fetch is forced
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk       in   1   single clock, all state on rising edge
  rst       in   1   synchronous, active-high reset
  d_req     in   1   data-stage request (rmmovq/mrmovq/call/ret/pushq/popq)
  d_we      in   1   data-stage write (1) / read (0)
  d_addr    in   64  data-stage word address
  d_wdata   in   64  data-stage write data
  d_ready   out  1   data request accepted this cycle
  d_rvalid  out  1   data response pulse
  d_rdata   out  64  data read result
  d_err     out  1   data response is an address error
  f_req     in   1   fetch-side read request
  f_addr    in   64  fetch word address
  f_ready   out  1   fetch request accepted this cycle
  f_rvalid  out  1   fetch response pulse
  f_rdata   out  64  fetch read result
  f_err     out  1   fetch response is an address error
  mem_en    out  1   memory access strobe
  mem_we    out  1   memory write enable
  mem_addr  out  10  memory word index (clog2 MEM_WORDS)
  mem_wdata out  64  memory write data
  mem_rdata in   64  memory read data, valid MEM_LAT cycles after mem_en

Function
REQ-003 FSM states IDLE, ISSUE, WAIT, RESP; one transaction in flight at most.
REQ-004 IDLE: if any req, assert exactly one of d_ready/f_ready combinationally, capture requester, we, addr, wdata; else stay.
REQ-005 Selection: only one requesting -> that one; both -> data, unless streak counter equals STARVE_LIMIT -> fetch.
REQ-006 Streak counter: +1 on data grant while f_req high; cleared on any fetch grant; saturates at STARVE_LIMIT.
REQ-007 Address check: addr >= MEM_WORDS -> error; IDLE -> RESP directly, no mem_en, rdata=0, err=1.
REQ-008 ISSUE (one cycle): mem_en=1, mem_we=captured we, mem_addr=addr[9:0], mem_wdata=captured wdata; fetch never writes.
REQ-009 WAIT: count MEM_LAT cycles, capture mem_rdata on final count, go RESP.
REQ-010 RESP (one cycle): winner's rvalid=1 with captured rdata (0 for writes), err=0; then IDLE.
REQ-011 Latency: rvalid exactly MEM_LAT+2 cycles after grant cycle; error rvalid grant+1; no grant in ISSUE/WAIT/RESP.
REQ-012 Requesters hold req/addr/wdata stable until ready; inputs ignored outside IDLE.
REQ-013 mem_en, d_rvalid, f_rvalid are single-cycle pulses; never both rvalids in one cycle.
REQ-014 rdata/err outputs hold 0 when their rvalid is low.

Reset
REQ-015 rst high at a clock edge: state IDLE, streak 0, all outputs 0, captured registers 0.
REQ-016 Reset mid-transaction drops the response; a write issued before reset stays committed; memory contents unaffected.

Structure
REQ-017 Package dmem_arb_pkg holds state enum, MEM_WORDS, MEM_LAT, STARVE_LIMIT, address-width constant.
REQ-018 One sub-module natural: dmem_arb_pick (request selection plus streak counter); memory array stays external.

Verification
REQ-019 Data write addr 5, data 0xDEAD_BEEF -> d_ready at t0, mem_en/we with mem_addr 5 at t1, d_rvalid at t3 with rdata 0 (MEM_LAT=1).
REQ-020 Fetch read addr 5 after REQ-019 -> f_rvalid at grant+3, f_rdata 0xDEAD_BEEF, f_err 0.
REQ-021 d_req and f_req held high continuously -> grant order D,D,F,D,D,F (STARVE_LIMIT=2).
REQ-022 d_addr 1024 read -> no mem_en, d_rvalid at grant+1, d_err 1, d_rdata 0.
REQ-023 rst asserted during WAIT -> next cycle IDLE, no rvalid, outputs 0; fresh request served normally.
REQ-024 MEM_LAT=3 read -> rvalid exactly 5 cycles after grant, no grant before RESP completes.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants, state encoding and address check for the data-memory arbiter
package dmem_arb_pkg;

    localparam int MEM_WORDS    = 1024;
    localparam int MEM_LAT      = 1;
    localparam int STARVE_LIMIT = 2;
    localparam int ADDR_W       = $clog2(MEM_WORDS);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Full 64-bit compare so high address bits can never alias into the array.
    function automatic logic addr_oob(input logic [63:0] addr, input int words);
        return addr >= 64'(words);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - data/fetch request selection with a streak counter that bounds fetch starvation
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = dmem_arb_pkg::STARVE_LIMIT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_d_req,
    input  logic i_f_req,
    output logic o_d_grant,
    output logic o_f_grant
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [SW-1:0] r_streak;
    logic          w_pref_f;

    assign w_pref_f  = (r_streak == SW'(STARVE_LIMIT));
    assign o_f_grant = i_en & i_f_req & (~i_d_req | w_pref_f);
    assign o_d_grant = i_en & i_d_req & (~i_f_req | ~w_pref_f);

    // Only contested data wins count toward the streak; it saturates at the limit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_streak <= '0;
        end else if (o_f_grant) begin
            r_streak <= '0;
        end else if (o_d_grant && i_f_req && !w_pref_f) begin
            r_streak <= r_streak + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory shared by fetch and data stages, one transaction in flight
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int  MEM_WORDS    = dmem_arb_pkg::MEM_WORDS,
    parameter int  MEM_LAT      = dmem_arb_pkg::MEM_LAT,
    parameter int  STARVE_LIMIT = dmem_arb_pkg::STARVE_LIMIT,
    localparam int AW           = $clog2(MEM_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [63:0]   i_d_addr,
    input  logic [63:0]   i_d_wdata,
    output logic          o_d_ready,
    output logic          o_d_rvalid,
    output logic [63:0]   o_d_rdata,
    output logic          o_d_err,
    input  logic          i_f_req,
    input  logic [63:0]   i_f_addr,
    output logic          o_f_ready,
    output logic          o_f_rvalid,
    output logic [63:0]   o_f_rdata,
    output logic          o_f_err,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [63:0]   o_mem_wdata,
    input  logic [63:0]   i_mem_rdata
);

    state_t        r_state;
    logic          r_sel_f;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [63:0]   r_wdata;
    logic [63:0]   r_rdata;
    logic          r_err;
    logic [1:0]    r_cnt;

    logic          w_grant_en;
    logic          w_d_grant;
    logic          w_f_grant;
    logic [63:0]   w_addr;
    logic          w_oob;
    logic          w_last;
    logic          w_issue;
    logic          w_resp;

    assign w_grant_en = (r_state == ST_IDLE) & ~i_rst;
    assign w_addr     = w_f_grant ? i_f_addr : i_d_addr;
    assign w_oob      = addr_oob(w_addr, MEM_WORDS);
    assign w_last     = (r_cnt == 2'(MEM_LAT - 1));

    dmem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (w_grant_en),
        .i_d_req  (i_d_req),
        .i_f_req  (i_f_req),
        .o_d_grant(w_d_grant),
        .o_f_grant(w_f_grant)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_sel_f <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_d_grant || w_f_grant) begin
                        r_sel_f <= w_f_grant;
                        r_we    <= w_d_grant & i_d_we;
                        r_addr  <= w_addr[AW-1:0];
                        r_wdata <= w_d_grant ? i_d_wdata : 64'd0;
                        r_rdata <= '0;
                        r_err   <= w_oob;
                        r_cnt   <= '0;
                        r_state <= w_oob ? ST_RESP : ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (w_last) begin
                        r_rdata <= r_we ? 64'd0 : i_mem_rdata;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_issue     = (r_state == ST_ISSUE);
    assign w_resp      = (r_state == ST_RESP);

    assign o_d_ready   = w_d_grant;
    assign o_f_ready   = w_f_grant;

    assign o_mem_en    = w_issue;
    assign o_mem_we    = w_issue & r_we;
    assign o_mem_addr  = w_issue ? r_addr : '0;
    assign o_mem_wdata = (w_issue & r_we) ? r_wdata : 64'd0;

    assign o_d_rvalid  = w_resp & ~r_sel_f;
    assign o_d_rdata   = o_d_rvalid ? r_rdata : 64'd0;
    assign o_d_err     = o_d_rvalid & r_err;
    assign o_f_rvalid  = w_resp & r_sel_f;
    assign o_f_rdata   = o_f_rvalid ? r_rdata : 64'd0;
    assign o_f_err     = o_f_rvalid & r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int SL  = 2;
    localparam int LAT = 1;

    typedef struct {
        bit          isf;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          lat;
        logic [63:0] rdata;
        bit          err;
        bit          en;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req, d_we, f_req;
    logic [63:0] d_addr, d_wdata, f_addr;

    logic        d_ready, d_rvalid, d_err, f_ready, f_rvalid, f_err, mem_en, mem_we;
    logic [63:0] d_rdata, f_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;
    logic        x_d_ready, x_d_rvalid, x_d_err, x_f_ready, x_f_rvalid, x_f_err, x_mem_en, x_mem_we;
    logic [63:0] x_d_rdata, x_f_rdata, x_mem_wdata, x_mem_rdata;
    logic [9:0]  x_mem_addr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_WORDS(1024), .MEM_LAT(LAT), .STARVE_LIMIT(SL)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_ready(d_ready), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata), .o_d_err(d_err),
        .i_f_req(f_req), .i_f_addr(f_addr),
        .o_f_ready(f_ready), .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata), .o_f_err(f_err),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.MEM_WORDS(1024), .MEM_LAT(3), .STARVE_LIMIT(SL)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_ready(x_d_ready), .o_d_rvalid(x_d_rvalid), .o_d_rdata(x_d_rdata), .o_d_err(x_d_err),
        .i_f_req(f_req), .i_f_addr(f_addr),
        .o_f_ready(x_f_ready), .o_f_rvalid(x_f_rvalid), .o_f_rdata(x_f_rdata), .o_f_err(x_f_err),
        .o_mem_en(x_mem_en), .o_mem_we(x_mem_we), .o_mem_addr(x_mem_addr), .o_mem_wdata(x_mem_wdata),
        .i_mem_rdata(x_mem_rdata)
    );

    // External memories; read data outside the valid window is poisoned.
    logic [63:0] mem1 [logic [9:0]];
    logic [63:0] mem3 [logic [9:0]];
    logic [63:0] p3 [3];
    logic [63:0] mref [logic [63:0]];

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem_we ? 64'hBAD : (mem1.exists(mem_addr) ? mem1[mem_addr] : 64'h0);
            if (mem_we) mem1[mem_addr] = mem_wdata;
        end else begin
            mem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    always @(posedge clk) begin
        if (x_mem_en) begin
            p3[0] <= x_mem_we ? 64'hBAD : (mem3.exists(x_mem_addr) ? mem3[x_mem_addr] : 64'h0);
            if (x_mem_we) mem3[x_mem_addr] = x_mem_wdata;
        end else begin
            p3[0] <= 64'hBAD0_BAD0_BAD0_BAD0;
        end
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign x_mem_rdata = p3[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0; f_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_txn(input int inst, input bit isf, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, output int lat, output logic [63:0] rd,
                          output bit er, output bit en1, output logic [9:0] a1);
        bit got;
        got = 1'b0; lat = -1; rd = '0; er = 1'b0; en1 = 1'b0; a1 = '0;
        @(posedge clk); #1;
        if (isf) begin
            f_req = 1'b1; f_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (inst == 3) ? (isf ? x_f_ready : x_d_ready) : (isf ? f_ready : d_ready);
            if (!got) begin @(posedge clk); #1; end
        end
        chk("grant", got, 1);
        @(posedge clk); #1;
        d_req = 1'b0; f_req = 1'b0; d_we = 1'b0;
        if (we && !isf && addr < 1024) mref[addr] = wdata;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                en1 = (inst == 3) ? x_mem_en : mem_en;
                a1  = (inst == 3) ? x_mem_addr : mem_addr;
            end
            if (inst == 3 ? (isf ? x_f_rvalid : x_d_rvalid) : (isf ? f_rvalid : d_rvalid)) begin
                lat = k;
                rd  = (inst == 3) ? (isf ? x_f_rdata : x_d_rdata) : (isf ? f_rdata : d_rdata);
                er  = (inst == 3) ? (isf ? x_f_err : x_d_err) : (isf ? f_err : d_err);
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    vec_t        tv[9];
    int          lat, ngr, drv, frc, streak, free_at, iss_cyc, rsp_cyc;
    logic [63:0] rd, drd, a, rsp_d, iss_wd;
    logic [9:0]  a1, iss_a;
    bit          er, en1, ed, ef, gf, dp, fp, rsp_f, rsp_e, iss_we;

    initial begin
        tv[0] = '{0, 1, 64'd5,    64'hDEAD_BEEF,            3, 64'h0,           0, 1};
        tv[1] = '{1, 0, 64'd5,    64'h0,                    3, 64'hDEAD_BEEF,   0, 1};
        tv[2] = '{0, 0, 64'd1024, 64'h0,                    1, 64'h0,           1, 0};
        tv[3] = '{0, 1, 64'd1023, 64'h1234_5678_9ABC_DEF0,  3, 64'h0,           0, 1};
        tv[4] = '{1, 0, 64'd1023, 64'h0,                    3, 64'h1234_5678_9ABC_DEF0, 0, 1};
        tv[5] = '{0, 0, 64'd5,    64'h0,                    3, 64'hDEAD_BEEF,   0, 1};
        tv[6] = '{1, 0, 64'h8000_0000_0000_0005, 64'h0,     1, 64'h0,           1, 0};
        tv[7] = '{0, 1, 64'h400,  64'h5555,                 1, 64'h0,           1, 0};
        tv[8] = '{0, 0, 64'd0,    64'h0,                    3, 64'h0,           0, 1};

        rst = 1'b1; d_req = 1'b0; d_we = 1'b0; f_req = 1'b0;
        d_addr = '0; d_wdata = '0; f_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_f_rvalid", f_rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_x_outs", {x_d_rvalid, x_f_rvalid, x_mem_en, x_d_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_txn(1, tv[i].isf, tv[i].we, tv[i].addr, tv[i].wdata, lat, rd, er, en1, a1);
            chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
            chk($sformatf("v%0d_rdata", i), rd, tv[i].rdata);
            chk($sformatf("v%0d_err", i), er, tv[i].err);
            chk($sformatf("v%0d_mem_en", i), en1, tv[i].en);
            if (tv[i].en) chk($sformatf("v%0d_mem_addr", i), a1, tv[i].addr);
        end

        // Both requesters held high: every (SL+1)th grant goes to fetch.
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'd1; f_req = 1'b1; f_addr = 64'd2;
        ngr = 0;
        for (int c = 0; c < 60 && ngr < 6; c++) begin
            @(negedge clk);
            chk("both_ready", d_ready & f_ready, 0);
            if (d_ready || f_ready) begin
                chk($sformatf("arb%0d_is_fetch", ngr), f_ready, (ngr % (SL + 1)) == SL);
                ngr++;
            end
            @(posedge clk); #1;
        end
        chk("arb_count", ngr, 6);
        d_req = 1'b0; f_req = 1'b0;

        // Reset while the write sits in WAIT: response dropped, write kept.
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'd9; d_wdata = 64'h77;
        @(negedge clk);
        chk("rstw_grant", d_ready, 1);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mref[64'd9] = 64'h77;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rstw_rvalid%0d", c), {d_rvalid, f_rvalid, d_err, mem_en}, 0);
            chk($sformatf("rstw_rdata%0d", c), d_rdata, 0);
            @(posedge clk); #1;
        end
        do_txn(1, 0, 0, 64'd9, 64'h0, lat, rd, er, en1, a1);
        chk("rstw_rd_lat", lat, 3);
        chk("rstw_rd_data", rd, 64'h77);

        // MEM_LAT=3 instance.
        do_reset();
        do_txn(3, 0, 1, 64'd3, 64'hABC, lat, rd, er, en1, a1);
        chk("l3_wr_lat", lat, 5);
        chk("l3_wr_rdata", rd, 0);
        chk("l3_wr_en", en1, 1);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'd3; f_req = 1'b1; f_addr = 64'd4;
        drv = -1; frc = -1; drd = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) chk("l3_dgrant", x_d_ready, 1);
            if (x_d_rvalid && drv < 0) begin drv = c; drd = x_d_rdata; end
            if (x_f_ready && frc < 0) frc = c;
            @(posedge clk); #1;
            if (c == 0) d_req = 1'b0;
            if (frc >= 0) f_req = 1'b0;
        end
        chk("l3_rd_lat", drv, 5);
        chk("l3_rd_data", drd, 64'hABC);
        chk("l3_fgrant_cycle", frc, 6);

        // Random traffic against a transaction-level model.
        do_reset();
        streak = 0; free_at = 0; iss_cyc = -1; rsp_cyc = -1;
        dp = 0; fp = 0; rsp_f = 0; rsp_e = 0; rsp_d = '0; iss_we = 0; iss_a = '0; iss_wd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = 64'($urandom_range(0, 1100)); d_wdata = {$urandom, $urandom};
            end
            if (!fp && $urandom_range(0, 1) == 1) begin
                fp = 1; f_addr = 64'($urandom_range(0, 1100));
            end
            d_req = dp; f_req = fp;
            @(negedge clk);
            ed = 0; ef = 0;
            if (cyc >= free_at && (dp || fp)) begin
                gf = fp && (!dp || streak == SL);
                ef = gf; ed = !gf;
                if (gf) streak = 0;
                else if (fp) streak = (streak < SL) ? streak + 1 : SL;
                a = gf ? f_addr : d_addr;
                rsp_f = gf;
                if (a >= 1024) begin
                    rsp_cyc = cyc + 1; rsp_e = 1; rsp_d = '0; free_at = cyc + 2;
                end else begin
                    iss_cyc = cyc + 1; iss_a = a[9:0]; iss_we = !gf && d_we; iss_wd = d_wdata;
                    rsp_cyc = cyc + LAT + 2; rsp_e = 0;
                    rsp_d = iss_we ? 64'h0 : (mref.exists(a) ? mref[a] : 64'h0);
                    if (iss_we) mref[a] = d_wdata;
                    free_at = cyc + LAT + 3;
                end
            end
            chk("r_d_ready", d_ready, ed);
            chk("r_f_ready", f_ready, ef);
            chk("r_mem_en", mem_en, cyc == iss_cyc);
            chk("r_mem_we", mem_we, (cyc == iss_cyc) && iss_we);
            chk("r_mem_addr", mem_addr, (cyc == iss_cyc) ? iss_a : 10'd0);
            if (cyc == iss_cyc && iss_we) chk("r_mem_wdata", mem_wdata, iss_wd);
            chk("r_d_rvalid", d_rvalid, (cyc == rsp_cyc) && !rsp_f);
            chk("r_d_rdata", d_rdata, ((cyc == rsp_cyc) && !rsp_f) ? rsp_d : 64'h0);
            chk("r_d_err", d_err, (cyc == rsp_cyc) && !rsp_f && rsp_e);
            chk("r_f_rvalid", f_rvalid, (cyc == rsp_cyc) && rsp_f);
            chk("r_f_rdata", f_rdata, ((cyc == rsp_cyc) && rsp_f) ? rsp_d : 64'h0);
            chk("r_f_err", f_err, (cyc == rsp_cyc) && rsp_f && rsp_e);
            if (ed) dp = 0;
            if (ef) fp = 0;
            @(posedge clk); #1;
        end
        d_req = 1'b0; f_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
